// File: rtl/decoder_scan_ctrl.sv
// -----------------------------------------------------------------------------
// decoder_scan_ctrl
//
// Drives the select (x, y) and enable (E) inputs of a downstream 2-to-4
// decoder. Steps through a masked subset of the four decoder channels and
// holds each channel for dwell+1 cycles. Supports single-sweep and continuous
// scanning, a sticky stop request and a one-cycle completion pulse.
//
// Build option:
//   SCAN_BLANK_EN  defined   -> after every channel visit, BLANK_CYC cycles
//                               with E=0 are inserted (BLANK state present).
//                  undefined -> no BLANK state; E stays high across channel
//                               changes and BLANK_CYC is unused.
//
// Parameters:
//   DWELL_W    width of the dwell field
//   BLANK_CYC  blanking cycles after each channel, 1..15
//
// Ports:
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous, active-high reset
//   start      in   begin a scan (sampled only in IDLE)
//   mode       in   0 = single sweep, 1 = continuous (latched at start)
//   dwell      in   per-channel active length minus one (latched at start)
//   ch_mask    in   channels to visit, bit n = channel n (latched at start)
//   stop       in   request termination (sampled while busy)
//   x          out  decoder select MSB (ch[1])
//   y          out  decoder select LSB (ch[0])
//   E          out  decoder enable
//   ch         out  current channel index
//   busy       out  high in ACTIVE and BLANK
//   done       out  one-cycle completion pulse
//   state_dbg  out  current FSM state encoding (debug observation)
//
// Handshake: start is a level qualifier, acted on only in the IDLE cycle in
// which it is seen with a non-zero ch_mask; there is no back-pressure. All
// outputs come directly from flops.
// -----------------------------------------------------------------------------
module decoder_scan_ctrl #(
   parameter int DWELL_W   = 8,
   parameter int BLANK_CYC = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               mode,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [3:0]         ch_mask,
   input  logic               stop,
   output logic               x,
   output logic               y,
   output logic               E,
   output logic [1:0]         ch,
   output logic               busy,
   output logic               done,
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_BLANK  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   // Lowest set bit of a 4-bit mask (0 when the mask is empty).
   function automatic logic [1:0] lowest_bit(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   // Next set bit strictly above cur; bit 2 of the result flags "found".
   function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   state_t             state_q, state_d;
   logic [1:0]         ch_q, ch_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [3:0]         mask_q, mask_d;
   logic               mode_q, mode_d;
   logic               stop_req_q, stop_req_d;
   logic               e_q, e_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               adv;
   logic [2:0]         nxt;

`ifdef SCAN_BLANK_EN
   localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYC - 1);
   logic [3:0] blank_cnt_q, blank_cnt_d;
`endif

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      cnt_d      = cnt_q;
      dwell_d    = dwell_q;
      mask_d     = mask_q;
      mode_d     = mode_q;
      stop_req_d = stop_req_q;
      adv        = 1'b0;
      nxt        = next_above(mask_q, ch_q);
`ifdef SCAN_BLANK_EN
      blank_cnt_d = blank_cnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start && (ch_mask != 4'd0)) begin
               dwell_d    = dwell;
               mask_d     = ch_mask;
               mode_d     = mode;
               ch_d       = lowest_bit(ch_mask);
               cnt_d      = '0;
               stop_req_d = 1'b0;
               state_d    = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (stop) stop_req_d = 1'b1;
            if (cnt_q == dwell_q) begin
               cnt_d = '0;
`ifdef SCAN_BLANK_EN
               blank_cnt_d = 4'd0;
               state_d     = S_BLANK;
`else
               adv = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BLANK: begin
`ifdef SCAN_BLANK_EN
            if (stop) stop_req_d = 1'b1;
            if (blank_cnt_q == BLANK_LAST) begin
               adv = 1'b1;
            end else begin
               blank_cnt_d = blank_cnt_q + 4'd1;
            end
`else
            state_d = S_IDLE;
`endif
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Advance point: a stop seen in this very cycle counts as well, since
      // the current channel has just completed its full dwell (and blank).
      if (adv) begin
         if (stop_req_q || stop) begin
            state_d = S_FINISH;
         end else if (nxt[2]) begin
            ch_d    = nxt[1:0];
            state_d = S_ACTIVE;
         end else if (mode_q) begin
            ch_d    = lowest_bit(mask_q);
            state_d = S_ACTIVE;
         end else begin
            state_d = S_FINISH;
         end
      end

      // Outputs are registered from the next state so they line up with it.
      e_d    = (state_d == S_ACTIVE);
      busy_d = (state_d == S_ACTIVE) || (state_d == S_BLANK);
      done_d = (state_d == S_FINISH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ch_q       <= 2'd0;
         cnt_q      <= '0;
         dwell_q    <= '0;
         mask_q     <= 4'd0;
         mode_q     <= 1'b0;
         stop_req_q <= 1'b0;
         e_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         cnt_q      <= cnt_d;
         dwell_q    <= dwell_d;
         mask_q     <= mask_d;
         mode_q     <= mode_d;
         stop_req_q <= stop_req_d;
         e_q        <= e_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

`ifdef SCAN_BLANK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         blank_cnt_q <= 4'd0;
      end else begin
         blank_cnt_q <= blank_cnt_d;
      end
   end
`endif

   assign x         = ch_q[1];
   assign y         = ch_q[0];
   assign ch        = ch_q;
   assign E         = e_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Sequencer that drives the select (`x`, `y`) and enable (`E`) inputs of the 2-to-4 decoder stage directly downstream. It steps through a masked set of the four decoder channels, holding each for a programmable dwell time. It supports single-sweep and continuous scanning, a stop request and a completion pulse. Typical uses are multiplexed display and row-scan front ends.

## Interface
- `DWELL_W`, 8, width of the dwell field; each channel stays active `dwell+1` cycles.
- `BLANK_CYC`, 1, number of blanking cycles (`E=0`) after each channel, 1..15. Used only when `SCAN_BLANK_EN` is defined.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a scan; sampled only in IDLE.
- `mode`  in  1  0 = single sweep, 1 = continuous; latched at start.
- `dwell`  in  DWELL_W  per-channel active length minus one; latched at start.
- `ch_mask`  in  4  channels to visit, bit n = channel n; latched at start.
- `stop`  in  1  requests termination; sampled while busy.
- `x`  out  1  decoder select MSB (`ch[1]`).
- `y`  out  1  decoder select LSB (`ch[0]`).
- `E`  out  1  decoder enable.
- `ch`  out  2  current channel index.
- `busy`  out  1  high in ACTIVE and BLANK.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ACTIVE, BLANK, FINISH. All outputs are registered.
- IDLE, when `start=1` and `ch_mask!=0`:
  - latch `dwell_q`, `mask_q`, `mode_q`;
  - `ch` <= lowest set bit of `ch_mask`;
  - clear the dwell counter and `stop_req`;
  - go to ACTIVE.
- IDLE with `start=1` and `ch_mask==0`: ignored; the block stays in IDLE and does not pulse `done`.
- ACTIVE:
  - `E=1`, `{x,y}=ch`, `busy=1`;
  - the counter runs from 0 up to `dwell_q`;
  - on `cnt==dwell_q`, go to BLANK, or advance directly if blanking is compiled out.
- BLANK:
  - `E=0`, `{x,y}` holds the last channel, `busy=1`;
  - lasts `BLANK_CYC` cycles, then advances.
- Advance:
  - If `stop_req` is set, go to FINISH.
  - Otherwise, take the next set bit of `mask_q` above `ch` and go to ACTIVE.
  - If there is no higher bit: `mode_q=1` wraps to the lowest set bit and goes to ACTIVE; `mode_q=0` goes to FINISH.
- FINISH: `done=1`, `busy=0`, `E=0` for exactly one cycle, then IDLE.
- `stop`:
  - `stop=1` while busy sets a sticky `stop_req`;
  - it is honoured only at the next advance point, so the current channel always completes its dwell and blank;
  - `stop` in IDLE or FINISH is ignored.
- `start` while busy or in FINISH is ignored. Changes to `dwell`, `ch_mask` or `mode` mid-scan have no effect.
- A mask with a single bit in continuous mode revisits the same channel indefinitely, with blanking between visits.

## Timing
- Reset values, one cycle after `rst=1` at a clock edge: state IDLE, `x=0`, `y=0`, `E=0`, `ch=0`, `busy=0`, `done=0`, `stop_req=0`, counter 0.
- `rst` has priority over all other inputs in every state. Asserting it mid-scan aborts without a `done` pulse.
- `start` sampled at edge t0: `E=1` and `busy=1` from cycle t0+1.
- Per channel: `E` high for `dwell_q+1` cycles, followed by `BLANK_CYC` cycles with `E` low.
- `done` is asserted in the cycle after the final ACTIVE or BLANK cycle.
- `{x,y}` changes only on the cycle `E` rises. When blanking is compiled out, it changes on the first ACTIVE cycle of the new channel.
- A new `start` is accepted no earlier than the cycle after `done`.

## Configuration
- Macro `SCAN_BLANK_EN`.
- Defined: BLANK state present; `BLANK_CYC` cycles with `E=0` follow every channel, including the last one.
- Undefined: no BLANK state. ACTIVE moves to the next channel or to FINISH straight after `cnt==dwell_q`. `E` stays high across channel changes. `BLANK_CYC` is unused.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `start=1` -> `E=0`, `busy=0`, `done=0`, `{x,y}=00`, and no scan starts.
- Single sweep, macro on, `BLANK_CYC=1`, `ch_mask=4'b1111`, `dwell=2`, start at t0:
  - `E=1` on cycles 1-3 (ch0), 5-7 (ch1), 9-11 (ch2), 13-15 (ch3);
  - `E=0` on cycles 4, 8, 12, 16;
  - `done` on cycle 17 only.
- Macro off, `ch_mask=4'b1010`, `dwell=0` -> `ch=1` on cycle 1, `ch=3` on cycle 2, `E=1` on both, `done` on cycle 3.
- Continuous, macro on, `BLANK_CYC=1`, `ch_mask=4'b0001`, `dwell=1`, `stop` pulsed on cycle 5:
  - `E=1` on cycles 1-2 and 4-5, `E=0` on cycles 3 and 6;
  - `done` on cycle 7; no further activity.
- `start` with `ch_mask=0` -> remains in IDLE, no `done`. `start` pulsed while busy -> sweep timing unchanged from the single-sweep case.
- `rst` asserted while `ch=2` and `E=1` -> reset values on the next cycle, no `done`. A fresh start then begins at the lowest set channel.
